regfile_pz: RTL and testbench

- Parametrised successor to the team's 16x16 two-read/one-write register file for the multicycle MIPS datapath.
- Generalises word width and register count, and optionally hardwires register 0 to zero.
- Adds a write-to-read bypass and a per-register busy scoreboard for multicycle hazard tracking.
- Adds a reset-driven init sequencer that loads register i with value i, so power-on contents come from a real reset rather than simulation-only initialisation.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/rf_scoreboard.sv | 39 +++
 rtl/regfile_pz.sv | 100 ++++++++++
 tb/tb_regfile_pz.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file and its scoreboard.
package regfile_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_t;

  localparam int unsigned INIT_MAX_W = 64;

  // Power-on value of register idx; callers cast down to their word width.
  function automatic logic [INIT_MAX_W-1:0] init_word(input logic [31:0] idx);
    return INIT_MAX_W'(idx);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set marks a pending producer, a write retires it.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH),
  parameter bit ZERO_REG = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic          busy_a,
  output logic          busy_b
);

  logic [DEPTH-1:0] busy;

  for (genvar i = 0; i < DEPTH; i++) begin : g_bit
    logic set_hit, clr_hit;
    // Register 0 never holds a pending producer when it is hardwired.
    assign set_hit = set_en && (set_addr == AW'(i)) && !(ZERO_REG && (i == 0));
    assign clr_hit = clr_en && (clr_addr == AW'(i));

    always_ff @(posedge clk) begin
      if (rst)          busy[i] <= 1'b0;
      else if (set_hit) busy[i] <= 1'b1;
      else if (clr_hit) busy[i] <= 1'b0;
    end
  end

  assign busy_a = busy[raddr_a];
  assign busy_b = busy[raddr_b];

endmodule

// File: rtl/regfile_pz.sv
// Two-read/one-write register file with reset-driven init, write bypass and busy scoreboard.
module regfile_pz
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH),
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             set_busy,
  input  logic [AW-1:0]    set_addr,
  output logic             busy_a,
  output logic             busy_b,
  output logic             ready,
  output logic             init_err
);

  rf_state_t               state, state_nxt;
  logic [AW-1:0]           cnt, cnt_nxt;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                    run;
  logic                    init_wr;
  logic                    user_wr;
  logic                    sb_busy_a, sb_busy_b;

  assign run     = (state == ST_RUN);
  assign ready   = run;
  assign init_wr = !rst && (state == ST_INIT);
  assign user_wr = !rst && run && we && !(ZERO_REG && (waddr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      cnt      <= '0;
      init_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      init_err <= (state == ST_INIT) && (we || set_busy);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == ST_INIT) begin
      cnt_nxt = cnt + AW'(1);
      if (cnt == AW'(DEPTH - 1)) state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (init_wr)      mem[cnt]   <= WIDTH'(init_word(32'(cnt)));
    else if (user_wr) mem[waddr] <= wdata;
  end

  // Bypass forwards only live writes; the hardwired zero overrides everything.
  function automatic logic [WIDTH-1:0] rd_port(input logic [AW-1:0] ra);
    logic [WIDTH-1:0] d;
    d = mem[ra];
    if (BYPASS && we && (waddr == ra)) d = wdata;
    if (ZERO_REG && (ra == '0))        d = '0;
    if (!run)                          d = '0;
    return d;
  endfunction

  assign rdata_a = rd_port(raddr_a);
  assign rdata_b = rd_port(raddr_b);

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (run && set_busy),
    .set_addr (set_addr),
    .clr_en   (run && we),
    .clr_addr (waddr),
    .raddr_a  (raddr_a),
    .raddr_b  (raddr_b),
    .busy_a   (sb_busy_a),
    .busy_b   (sb_busy_b)
  );

  assign busy_a = run && sb_busy_a;
  assign busy_b = run && sb_busy_b;

endmodule

// File: tb/tb_regfile_pz.sv
// Scoreboard bench: three configurations share one stimulus stream.
module tb_regfile_pz;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] raddr_a, raddr_b, waddr, set_addr;
  logic          we, set_busy;
  logic [W-1:0]  wdata;

  logic [W-1:0] rda_b1, rdb_b1, rda_b0, rdb_b0, rda_z, rdb_z;
  logic         bsa_b1, bsb_b1, bsa_b0, bsb_b0, bsa_z, bsb_z;
  logic         rdy_b1, rdy_b0, rdy_z, err_b1, err_b0, err_z;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  regfile_pz #(.WIDTH(W), .DEPTH(D), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut_b1 (
    .clk(clk), .rst(rst), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rda_b1), .rdata_b(rdb_b1), .we(we), .waddr(waddr), .wdata(wdata),
    .set_busy(set_busy), .set_addr(set_addr), .busy_a(bsa_b1), .busy_b(bsb_b1),
    .ready(rdy_b1), .init_err(err_b1));

  regfile_pz #(.WIDTH(W), .DEPTH(D), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_b0 (
    .clk(clk), .rst(rst), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rda_b0), .rdata_b(rdb_b0), .we(we), .waddr(waddr), .wdata(wdata),
    .set_busy(set_busy), .set_addr(set_addr), .busy_a(bsa_b0), .busy_b(bsb_b0),
    .ready(rdy_b0), .init_err(err_b0));

  regfile_pz #(.WIDTH(W), .DEPTH(D), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_z (
    .clk(clk), .rst(rst), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rda_z), .rdata_b(rdb_z), .we(we), .waddr(waddr), .wdata(wdata),
    .set_busy(set_busy), .set_addr(set_addr), .busy_a(bsa_z), .busy_b(bsb_z),
    .ready(rdy_z), .init_err(err_z));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0:  return 32'(rda_b1);
      1:  return 32'(rdb_b1);
      2:  return 32'(bsa_b1);
      3:  return 32'(bsb_b1);
      4:  return 32'(rdy_b1);
      5:  return 32'(err_b1);
      6:  return 32'(rda_b0);
      7:  return 32'(rda_z);
      8:  return 32'(bsa_z);
      9:  return 32'(rdy_b0);
      10: return 32'(rdy_z);
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sbq.push_back(e);
  endtask

  // Compare everything queued for this cycle mid-period, then advance one edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk(e.tag, obs(e.sel), e.exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; set_busy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; set_busy = 1'b0;
    raddr_a = '0; raddr_b = '0; waddr = '0; set_addr = '0; wdata = '0;
    @(posedge clk); #1;

    push("rst_ready", 4, 0); push("rst_err", 5, 0); push("rst_busy", 2, 0);
    step();

    // Init: exactly D cycles with ready low, reads gated to zero.
    rst = 1'b0; raddr_a = 4'd5; raddr_b = 4'd15;
    for (int i = 0; i < D; i++) begin
      push("init_ready", 4, 0); push("init_rd", 0, 0);
      step();
    end
    push("ready_up", 4, 1); push("ready_up_nb", 9, 1); push("ready_up_z", 10, 1);
    push("init_r5", 0, 32'h5); push("init_r15", 1, 32'hF);
    step();

    // Write with bypass vs. without.
    we = 1'b1; waddr = 4'd3; wdata = 16'hBEEF; raddr_a = 4'd3;
    push("byp_on", 0, 32'hBEEF); push("byp_off", 6, 32'h3);
    step();
    idle();
    push("wr_after", 0, 32'hBEEF); push("wr_after_nb", 6, 32'hBEEF);
    step();

    // Scoreboard set, hold, clear-by-write, and set-wins-over-clear.
    set_busy = 1'b1; set_addr = 4'd7; raddr_b = 4'd7;
    push("busy_pre", 3, 0);
    step();
    idle();
    push("busy_set", 3, 1);
    step();
    push("busy_hold", 3, 1);
    step();
    we = 1'b1; waddr = 4'd7; wdata = 16'h0777;
    push("busy_clr_cyc", 3, 1); push("byp_b", 1, 32'h0777);
    step();
    idle();
    push("busy_cleared", 3, 0); push("r7", 1, 32'h0777);
    step();
    we = 1'b1; set_busy = 1'b1; waddr = 4'd7; set_addr = 4'd7; wdata = 16'h0778;
    push("set_clr_cyc", 3, 0);
    step();
    idle();
    push("set_wins", 3, 1);
    step();

    // Hardwired zero register.
    we = 1'b1; waddr = 4'd0; wdata = 16'h1234; raddr_a = 4'd0;
    push("z_byp", 7, 0); push("nz_byp", 0, 32'h1234);
    step();
    we = 1'b0; set_busy = 1'b1; set_addr = 4'd0;
    push("z_after", 7, 0); push("nz_after", 0, 32'h1234);
    step();
    idle();
    push("z_busy", 8, 0); push("nz_busy", 2, 1);
    step();

    // Reset mid-operation after dirtying reg 9.
    we = 1'b1; waddr = 4'd9; wdata = 16'hAAAA; raddr_a = 4'd9;
    step();
    idle();
    push("r9_aaaa", 0, 32'hAAAA);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push("init1_ready", 4, 0);
      step();
    end
    rst = 1'b1;
    push("rst_mid_ready", 4, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < D; i++) begin
      push("init2_ready", 4, 0); push("init2_rd", 0, 0);
      if (i == 3) begin
        we = 1'b1; waddr = 4'd9; wdata = 16'hFFFF;
        set_busy = 1'b1; set_addr = 4'd9;
        push("err_quiet", 5, 0);
      end else begin
        idle();
        if (i == 4) push("err_pulse", 5, 1);
        if (i == 5) push("err_drop", 5, 0);
      end
      step();
    end
    idle();
    raddr_a = 4'd9; raddr_b = 4'd7;
    push("ready2", 4, 1); push("r9_reinit", 0, 32'h9);
    push("busy9_clr", 2, 0); push("busy7_clr", 3, 0);
    step();
    raddr_a = 4'd0; raddr_b = 4'd3;
    push("r0_reinit", 0, 0); push("r3_reinit", 1, 32'h3);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
